// File: rtl/gate_guesser_pkg.sv
// Shared definitions for the gate-guessing game: gate codes, game states
// and the single-bit gate evaluator used by every channel.
package gate_guesser_pkg;

   typedef enum logic [2:0] {
      G_AND  = 3'd0,
      G_OR   = 3'd1,
      G_XOR  = 3'd2,
      G_NAND = 3'd3,
      G_NOR  = 3'd4,
      G_XNOR = 3'd5,
      G_ANDN = 3'd6,
      G_NOTA = 3'd7
   } gate_code_e;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_SCRAMBLE = 2'd1,
      ST_PLAY     = 2'd2,
      ST_DONE     = 2'd3
   } game_state_e;

   // Galois feedback mask for taps 16/14/13/11
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   function automatic logic gate_eval(input logic [2:0] code, input logic a, input logic b);
      logic y;
      case (gate_code_e'(code))
         G_AND:   y = a & b;
         G_OR:    y = a | b;
         G_XOR:   y = a ^ b;
         G_NAND:  y = ~(a & b);
         G_NOR:   y = ~(a | b);
         G_XNOR:  y = ~(a ^ b);
         G_ANDN:  y = a & ~b;
         G_NOTA:  y = ~a;
         default: y = 1'b0;
      endcase
      return y;
   endfunction

endpackage

// File: rtl/gg_lfsr.sv
// Free-running 16-bit Galois LFSR that supplies the scramble bits.
// A stuck-at-zero state is recovered by reloading the seed.
module gg_lfsr
   import gate_guesser_pkg::*;
#(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ena,
   output logic [15:0] lfsr
);

   // Shift right, folding the dropped bit back through the tap mask
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr <= SEED;
      end else if (ena) begin
         if (lfsr == 16'h0000) begin
            lfsr <= SEED;
         end else begin
            lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
         end
      end
   end

endmodule

// File: rtl/gate_guesser_core.sv
// Gate-guessing game: hidden per-channel gates are scrambled from an LFSR,
// the player guesses each channel's gate code until solved or out of misses.
module gate_guesser_core
   import gate_guesser_pkg::*;
#(
   parameter int          NUM_GATES  = 8,
   parameter int          SCORE_W    = 8,
   parameter int          MAX_MISSES = 3,
   parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         ena,
   input  logic [NUM_GATES-1:0]         sw_a,
   input  logic [NUM_GATES-1:0]         sw_b,
   input  logic                         new_game,
   input  logic                         guess_valid,
   input  logic [$clog2(NUM_GATES)-1:0] guess_ch,
   input  logic [2:0]                   guess_type,
   output logic [NUM_GATES-1:0]         gate_out,
   output logic [NUM_GATES-1:0]         solved,
   output logic [SCORE_W-1:0]           score,
   output logic [3:0]                   misses,
   output logic [1:0]                   game_state,
   output logic                         result_valid,
   output logic                         result_hit
);

   localparam int CH_W = $clog2(NUM_GATES);

   game_state_e                 state_r, state_nxt;
   logic [CH_W-1:0]             scr_cnt_r, scr_cnt_nxt;
   logic [NUM_GATES-1:0][2:0]   type_r, type_nxt;
   logic [NUM_GATES-1:0]        solved_nxt, gate_nxt;
   logic [SCORE_W-1:0]          score_nxt;
   logic [3:0]                  misses_nxt;
   logic                        rv_nxt, rh_nxt;
   logic                        ng_d_r, gv_d_r;
   logic                        ng_edge_s, gv_edge_s, ch_ok_s, hit_s;
   logic [2:0]                  sel_type_s;
   logic [15:0]                 lfsr_s;
   logic [12:0]                 unused_lfsr;

   gg_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
      .clk   (clk),
      .rst_n (rst_n),
      .ena   (ena),
      .lfsr  (lfsr_s)
   );

   assign unused_lfsr = lfsr_s[15:3];
   assign ng_edge_s   = new_game & ~ng_d_r;
   assign gv_edge_s   = guess_valid & ~gv_d_r;
   assign game_state  = state_r;

   // Next-state, scoring and gate-output evaluation
   always_comb begin
      state_nxt   = state_r;
      scr_cnt_nxt = scr_cnt_r;
      type_nxt    = type_r;
      solved_nxt  = solved;
      score_nxt   = score;
      misses_nxt  = misses;
      rv_nxt      = 1'b0;
      rh_nxt      = 1'b0;
      sel_type_s  = 3'd0;
      for (int i = 0; i < NUM_GATES; i++) begin
         sel_type_s = (guess_ch == CH_W'(i)) ? type_r[i] : sel_type_s;
      end
      ch_ok_s = (int'(guess_ch) < NUM_GATES);
      hit_s   = (guess_type == sel_type_s);

      if (ng_edge_s) begin
         state_nxt   = ST_SCRAMBLE;
         scr_cnt_nxt = '0;
         solved_nxt  = '0;
         score_nxt   = '0;
         misses_nxt  = 4'd0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               state_nxt = ST_IDLE;
            end
            ST_SCRAMBLE: begin
               type_nxt[scr_cnt_r] = lfsr_s[2:0];
               scr_cnt_nxt         = scr_cnt_r + CH_W'(1);
               if (scr_cnt_r == CH_W'(NUM_GATES - 1)) begin
                  state_nxt = ST_PLAY;
               end else begin
                  state_nxt = ST_SCRAMBLE;
               end
            end
            ST_PLAY: begin
               // A fully solved board ends the game before any further guess
               if (&solved) begin
                  state_nxt = ST_DONE;
               end else if (gv_edge_s && ch_ok_s) begin
                  rv_nxt = 1'b1;
                  rh_nxt = hit_s;
                  if (hit_s) begin
                     if (!solved[guess_ch] && (score != {SCORE_W{1'b1}})) begin
                        score_nxt = score + SCORE_W'(1);
                     end else begin
                        score_nxt = score;
                     end
                     solved_nxt[guess_ch] = 1'b1;
                  end else begin
                     misses_nxt = misses + 4'd1;
                     if (misses + 4'd1 == 4'(MAX_MISSES)) begin
                        state_nxt  = ST_DONE;
                        solved_nxt = '1;
                     end else begin
                        state_nxt = ST_PLAY;
                     end
                  end
               end else begin
                  state_nxt = ST_PLAY;
               end
            end
            ST_DONE: begin
               state_nxt = ST_DONE;
            end
            default: begin
               state_nxt = ST_IDLE;
            end
         endcase
      end

      for (int i = 0; i < NUM_GATES; i++) begin
         if (state_nxt == ST_PLAY || state_nxt == ST_DONE) begin
            gate_nxt[i] = gate_eval(type_nxt[i], sw_a[i], sw_b[i]);
         end else begin
            gate_nxt[i] = 1'b0;
         end
      end
   end

   // Game state registers; everything freezes while ena is low
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= ST_IDLE;
         scr_cnt_r    <= '0;
         type_r       <= '0;
         gate_out     <= '0;
         solved       <= '0;
         score        <= '0;
         misses       <= 4'd0;
         result_valid <= 1'b0;
         result_hit   <= 1'b0;
         ng_d_r       <= 1'b0;
         gv_d_r       <= 1'b0;
      end else if (ena) begin
         state_r      <= state_nxt;
         scr_cnt_r    <= scr_cnt_nxt;
         type_r       <= type_nxt;
         gate_out     <= gate_nxt;
         solved       <= solved_nxt;
         score        <= score_nxt;
         misses       <= misses_nxt;
         result_valid <= rv_nxt;
         result_hit   <= rh_nxt;
         ng_d_r       <= new_game;
         gv_d_r       <= guess_valid;
      end
   end

endmodule

// File: doc/gate_guesser_core.md
GATE_GUESSER_CORE -- requirements
Module: gate_guesser_core

Interface
REQ-001: Parameter NUM_GATES, default 8, number of hidden-gate channels (2..16).
REQ-002: Parameter SCORE_W, default 8, width of the score counter.
REQ-003: Parameter MAX_MISSES, default 3, wrong guesses allowed before game over (1..15).
REQ-004: Parameter LFSR_SEED, default 16'hACE1, non-zero LFSR reset value.
REQ-005: clk  in  1  single clock; all state updates on its rising edge.
REQ-006: rst_n  in  1  reset, asynchronous and active-low.
REQ-007: ena  in  1  high = run; low = hold all state, outputs keep last value.
REQ-008: sw_a  in  NUM_GATES  operand A per channel.
REQ-009: sw_b  in  NUM_GATES  operand B per channel.
REQ-010: new_game  in  1  level button, internally rising-edge detected.
REQ-011: guess_valid  in  1  level button, internally rising-edge detected.
REQ-012: guess_ch  in  clog2(NUM_GATES)  channel being guessed.
REQ-013: guess_type  in  3  guessed gate code.
REQ-014: gate_out  out  NUM_GATES  registered result of each hidden gate.
REQ-015: solved  out  NUM_GATES  per-channel solved flags.
REQ-016: score  out  SCORE_W  correct guesses this game.
REQ-017: misses  out  4  wrong guesses this game.
REQ-018: game_state  out  2  IDLE=0, SCRAMBLE=1, PLAY=2, DONE=3.
REQ-019: result_valid  out  1  one-cycle pulse when a guess is judged.
REQ-020: result_hit  out  1  verdict, valid only with result_valid.

Function
REQ-021: Gate codes SHALL be 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 A-AND-NOT-B, 7 NOT-A.
REQ-022: 16-bit Galois LFSR, taps 16/14/13/11, SHALL advance every ena cycle in every state; a zero value SHALL reload LFSR_SEED.
REQ-023: FSM: IDLE -new_game edge-> SCRAMBLE; SCRAMBLE lasts exactly NUM_GATES cycles, cycle i loading type[i] = lfsr[2:0], then -> PLAY.
REQ-024: Entering SCRAMBLE SHALL clear solved, score, misses.
REQ-025: gate_out[i] SHALL equal f(type[i], sw_a[i], sw_b[i]) with one-cycle latency in PLAY and DONE; 0 in IDLE and SCRAMBLE.
REQ-026: A guess_valid edge in PLAY SHALL be judged next cycle: result_valid=1, result_hit=(guess_type==type[guess_ch]).
REQ-027: Hit on unsolved channel: set solved[ch], score +1 saturating at all-ones.
REQ-028: Hit on solved channel: result_hit=1, no score change.
REQ-029: Miss: misses +1; when misses reaches MAX_MISSES -> DONE the same cycle.
REQ-030: All solved bits set -> DONE on the cycle after the final hit.
REQ-031: guess_ch >= NUM_GATES SHALL be ignored: no result pulse, no count change.
REQ-032: Guess edges outside PLAY SHALL be ignored.
REQ-033: DONE holds score/misses; solved SHALL read all-ones (reveal); new_game edge -> SCRAMBLE.
REQ-034: new_game edge in any state including SCRAMBLE SHALL restart SCRAMBLE; same-cycle with a guess, new_game wins and the guess is dropped.
REQ-035: Held buttons SHALL produce exactly one event per rising edge.

Reset
REQ-036: rst_n low SHALL force IDLE, lfsr=LFSR_SEED, types=0, gate_out=0, solved=0, score=0, misses=0, result_valid=0, result_hit=0, edge-detect registers=0.
REQ-037: Reset mid-game SHALL discard all game state with no result pulse on release.

Structure
REQ-038: Package gate_guesser_pkg SHALL hold the gate-code enum, FSM state enum and the gate-evaluation function.
REQ-039: LFSR SHALL be sub-module gg_lfsr (seed parameter, ena, 16-bit state out).

Verification
REQ-040: Reset, seed 16'hACE1 -> IDLE, all outputs 0, lfsr=16'hACE1.
REQ-041: new_game edge -> SCRAMBLE for 8 cycles, PLAY next; each type matches model LFSR; gate_out matches model across all 4 operand combos.
REQ-042: Correct guesses on all 8 channels -> 8 hit pulses, score=8, DONE; repeat guess on a solved channel mid-game -> hit, score unchanged.
REQ-043: Three wrong guesses -> misses=3, DONE after third; fourth guess -> no pulse.
REQ-044: guess_ch=9 with NUM_GATES=8 style range test (NUM_GATES=6, guess_ch=7) -> no pulse; guess_valid held 20 cycles -> one pulse.
REQ-045: ena low 10 cycles mid-PLAY -> state, lfsr, outputs frozen; rst_n low mid-PLAY -> IDLE, counters 0.
